// File: rtl/brisc_pkg.sv
// Shared constants for the branch issue unit: opcodes, instruction field widths
// and FSM state encoding.
package brisc_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 4'hB;
  localparam logic [OPCODE_W-1:0] OP_JN   = 4'hC;
  localparam logic [OPCODE_W-1:0] OP_CALL = 4'hD;
  localparam logic [OPCODE_W-1:0] OP_RET  = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    HALTED   = 2'd3
  } state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses for CALL/RET. The top entry is readable combinationally
// so RET can resolve its target in the decode cycle.
module return_stack
  import brisc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              data_in,
  output logic [ADDR_W-1:0]              data_out,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(STACK_DEPTH):0]   depth
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  logic [ADDR_W-1:0]  mem [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_reg;
  logic [PTR_W-1:0]   wr_idx;
  logic [PTR_W-1:0]   top_idx;

  assign full    = (depth_reg == DEPTH_W'(STACK_DEPTH));
  assign empty   = (depth_reg == '0);
  assign wr_idx  = depth_reg[PTR_W-1:0];
  assign top_idx = wr_idx - PTR_W'(1);
  assign data_out = mem[top_idx];
  assign depth   = depth_reg;

  // Storage needs no reset: only entries below depth_reg are ever read meaningfully.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      depth_reg <= depth_reg + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_reg <= depth_reg - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/branch_issue_unit.sv
// Decodes branch instructions at the current PC and drives a held jump request to
// the PC controller until the PC shows the target; tracks CALL/RET return addresses.
module branch_issue_unit
  import brisc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4,
  parameter int MAX_PC      = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_done,
  input  logic [ADDR_W-1:0]             program_counter,
  input  logic [INSTR_W-1:0]            instr,
  input  logic                          instr_valid,
  input  logic                          zero_flag,
  input  logic                          neg_flag,
  output logic                          jump_en,
  output logic [ADDR_W-1:0]             jump_address,
  output logic                          halt,
  output logic                          stack_err,
  output logic [$clog2(STACK_DEPTH):0]  stack_depth
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   target_reg, target_next;
  logic [ADDR_W-1:0]   jump_address_reg, jump_address_next;
  logic                jump_en_reg, jump_en_next;
  logic                halt_reg, halt_next;
  logic                stack_err_reg, stack_err_next;
  logic                wait_first_reg, wait_first_next;

  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   instr_target;
  logic                push, pop, stack_full, stack_empty;
  logic [ADDR_W-1:0]   stack_top;
  logic                taken, bad_stack, hlt_seen;
  logic [ADDR_W-1:0]   branch_target;
  logic                unused_instr_bits;

  assign opcode            = instr[INSTR_W-1 -: OPCODE_W];
  assign instr_target      = instr[ADDR_W-1:0];
  assign unused_instr_bits = ^instr[INSTR_W-OPCODE_W-1:ADDR_W];

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (program_counter + ADDR_W'(1)),
    .data_out (stack_top),
    .full     (stack_full),
    .empty    (stack_empty),
    .depth    (stack_depth)
  );

  always_comb begin
    state_next        = state_reg;
    target_next       = target_reg;
    jump_address_next = jump_address_reg;
    jump_en_next      = jump_en_reg;
    halt_next         = halt_reg;
    stack_err_next    = stack_err_reg;
    wait_first_next   = wait_first_reg;
    push              = 1'b0;
    pop               = 1'b0;
    taken             = 1'b0;
    bad_stack         = 1'b0;
    hlt_seen          = 1'b0;
    branch_target     = instr_target;

    case (state_reg)
      IDLE: begin
        if (load_done) begin
          if (instr_valid) begin
            case (opcode)
              OP_JMP:  taken = 1'b1;
              OP_JZ:   taken = zero_flag;
              OP_JN:   taken = neg_flag;
              OP_CALL: begin
                bad_stack = stack_full;
                push      = !stack_full;
                taken     = !stack_full;
              end
              OP_RET: begin
                bad_stack     = stack_empty;
                pop           = !stack_empty;
                taken         = !stack_empty;
                branch_target = stack_top;
              end
              OP_HLT:  hlt_seen = 1'b1;
              default: taken = 1'b0;
            endcase
          end
          // A taken branch at the last address wins; the boundary check reruns after it.
          if (bad_stack || hlt_seen) begin
            stack_err_next = stack_err_reg | bad_stack;
            halt_next      = 1'b1;
            state_next     = HALTED;
          end else if (taken) begin
            target_next = branch_target;
            state_next  = ISSUE;
          end else if (program_counter == ADDR_W'(MAX_PC)) begin
            halt_next  = 1'b1;
            state_next = HALTED;
          end
        end
      end
      ISSUE: begin
        jump_address_next = target_reg;
        jump_en_next      = 1'b1;
        wait_first_next   = 1'b1;
        state_next        = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Skipping the first cycle lets a jump-to-self be seen as a fresh PC load.
        wait_first_next = 1'b0;
        if (!wait_first_reg && (program_counter == jump_address_reg)) begin
          jump_en_next = 1'b0;
          state_next   = IDLE;
        end
      end
      HALTED: begin
        jump_en_next = 1'b0;
        halt_next    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      target_reg       <= '0;
      jump_address_reg <= '0;
      jump_en_reg      <= 1'b0;
      halt_reg         <= 1'b0;
      stack_err_reg    <= 1'b0;
      wait_first_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      target_reg       <= target_next;
      jump_address_reg <= jump_address_next;
      jump_en_reg      <= jump_en_next;
      halt_reg         <= halt_next;
      stack_err_reg    <= stack_err_next;
      wait_first_reg   <= wait_first_next;
    end
  end

  assign jump_en      = jump_en_reg;
  assign jump_address = jump_address_reg;
  assign halt         = halt_reg;
  assign stack_err    = stack_err_reg;

endmodule
